// File: rtl/entropy_bit_collector_if.sv
// Bus between the raw-entropy source/conditioner side and the bit collector.
// The slave modport is the collector's view; master is the driver/observer side.
interface entropy_bit_collector_if #(
    parameter int BUF_BITS = 1024,
    parameter int IDX_W    = 10,
    parameter int RUN_W    = 5
);
    logic                bit_in;
    logic                bit_valid;
    logic                block_ready;
    logic                clear_failure;
    logic [BUF_BITS-1:0] random_bits;
    logic [IDX_W-1:0]    index_of_last_bit;
    logic                block_valid;
    logic [RUN_W-1:0]    run_length;
    logic                rct_failure;
    logic                bit_dropped;

    modport master (
        output bit_in, bit_valid, block_ready, clear_failure,
        input  random_bits, index_of_last_bit, block_valid, run_length,
               rct_failure, bit_dropped
    );

    modport slave (
        input  bit_in, bit_valid, block_ready, clear_failure,
        output random_bits, index_of_last_bit, block_valid, run_length,
               rct_failure, bit_dropped
    );
endinterface

// File: rtl/entropy_bit_collector.sv
// Writes serial raw entropy bits into a circular window, hands full blocks to the
// conditioner and runs a sequential repetition-count health test with sticky fault.
module entropy_bit_collector #(
    parameter int BUF_BITS   = 1024,
    parameter int IDX_W      = 10,
    parameter int RCT_CUTOFF = 23,
    parameter int RUN_W      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    entropy_bit_collector_if.slave  bus
);
    typedef enum logic [1:0] {FILL, FULL, FAULT} state_t;

    state_t              state, state_nxt;
    logic [BUF_BITS-1:0] random_bits_q;
    logic [IDX_W-1:0]    idx_q, wr_ptr;
    logic [IDX_W:0]      fill_count, fill_nxt;
    logic [RUN_W-1:0]    run_q, run_inc, run_nxt;
    logic                bv_q, rct_q, drop_q;
    logic                bv_nxt, rct_nxt, drop_nxt;
    logic                accept, last_bit, fault_hit, full_hit;

    // The previous accepted bit is always the one at index_of_last_bit; a zero
    // run length marks "no previous bit" after reset or clear.
    always_comb begin
        accept    = (state == FILL) && bus.bit_valid;
        last_bit  = random_bits_q[idx_q];
        if (run_q == '0 || bus.bit_in != last_bit)
            run_inc = RUN_W'(1);
        else if (run_q == RUN_W'(RCT_CUTOFF))
            run_inc = run_q;
        else
            run_inc = run_q + RUN_W'(1);
        fault_hit = accept && (run_inc == RUN_W'(RCT_CUTOFF));
        full_hit  = accept && (fill_count == (IDX_W+1)'(BUF_BITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (fault_hit) state_nxt = FAULT;
                     else if (full_hit) state_nxt = FULL;
            FULL:    if (bus.block_ready) state_nxt = FILL;
            FAULT:   if (bus.clear_failure) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        drop_nxt = bus.bit_valid && (state != FILL);
        bv_nxt   = (state_nxt == FULL);
        rct_nxt  = (state_nxt == FAULT);
        run_nxt  = run_q;
        if (accept)
            run_nxt = run_inc;
        else if (state == FAULT && bus.clear_failure)
            run_nxt = '0;
        fill_nxt = fill_count;
        if (state_nxt == FAULT || (state == FULL && bus.block_ready))
            fill_nxt = '0;
        else if (accept)
            fill_nxt = fill_count + (IDX_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            random_bits_q <= '0;
            idx_q         <= '0;
            wr_ptr        <= '0;
            fill_count    <= '0;
            run_q         <= '0;
            bv_q          <= 1'b0;
            rct_q         <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            if (accept) begin
                random_bits_q[wr_ptr] <= bus.bit_in;
                idx_q                 <= wr_ptr;
                wr_ptr                <= wr_ptr + IDX_W'(1);
            end
            fill_count <= fill_nxt;
            run_q      <= run_nxt;
            bv_q       <= bv_nxt;
            rct_q      <= rct_nxt;
            drop_q     <= drop_nxt;
        end
    end

    assign bus.random_bits       = random_bits_q;
    assign bus.index_of_last_bit = idx_q;
    assign bus.block_valid       = bv_q;
    assign bus.run_length        = run_q;
    assign bus.rct_failure       = rct_q;
    assign bus.bit_dropped       = drop_q;
endmodule

// File: tb/tb_entropy_bit_collector.sv
// Directed bench for entropy_bit_collector: block fill/handshake, drops,
// repetition-count fault and clear, run across block boundary, mid-block reset.
module tb_entropy_bit_collector;
    localparam int BUF_BITS = 1024;
    localparam int IDX_W    = 10;
    localparam int RUN_W    = 5;

    logic                clk = 1'b0;
    logic                rst;
    int                  checks = 0;
    int                  errors = 0;
    int                  p;
    logic                b;
    logic [BUF_BITS-1:0] exp_buf;

    entropy_bit_collector_if #(.BUF_BITS(BUF_BITS), .IDX_W(IDX_W), .RUN_W(RUN_W)) bus();

    entropy_bit_collector #(
        .BUF_BITS(BUF_BITS), .IDX_W(IDX_W), .RCT_CUTOFF(23), .RUN_W(RUN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BUF_BITS-1:0] got,
                       input logic [BUF_BITS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one input cycle, returns at the next negedge.
    task automatic step(input logic v, input logic bit_v);
        bus.bit_valid = v;
        bus.bit_in    = bit_v;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_failure = 1'b1;
        @(negedge clk);
        bus.clear_failure = 1'b0;
    endtask

    initial begin
        bus.bit_in = 0; bus.bit_valid = 0; bus.block_ready = 0; bus.clear_failure = 0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_bits", bus.random_bits, '0);
        chk("rst_idx", bus.index_of_last_bit, 0);
        chk("rst_bv", bus.block_valid, 0);
        chk("rst_run", bus.run_length, 0);
        chk("rst_rct", bus.rct_failure, 0);
        chk("rst_drop", bus.bit_dropped, 0);

        // Block of alternating bits 0,1,0,...
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, i[0]);
            if (i == 0)    chk("first_idx", bus.index_of_last_bit, 0);
            if (i == 1022) chk("bv_early", bus.block_valid, 0);
        end
        exp_buf = {512{2'b10}};
        chk("full_bv", bus.block_valid, 1);
        chk("full_idx", bus.index_of_last_bit, 1023);
        chk("full_bits", bus.random_bits, exp_buf);
        chk("full_rct", bus.rct_failure, 0);
        chk("full_run", bus.run_length, 1);

        // FULL with no ready: every presented bit is dropped
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1);
            chk("drop_full", bus.bit_dropped, 1);
        end
        chk("hold_bits", bus.random_bits, exp_buf);
        chk("hold_idx", bus.index_of_last_bit, 1023);
        chk("hold_bv", bus.block_valid, 1);

        bus.block_ready = 1'b1;
        step(1'b1, 1'b1);
        bus.block_ready = 1'b0;
        chk("hs_bv", bus.block_valid, 0);
        chk("hs_drop", bus.bit_dropped, 1);
        chk("hs_bits", bus.random_bits, exp_buf);

        step(1'b1, 1'b0);
        chk("wrap_idx0", bus.index_of_last_bit, 0);
        chk("wrap_run", bus.run_length, 1);
        chk("idle_drop", bus.bit_dropped, 0);

        // 22 ones: no fault; 23rd: fault
        for (int k = 0; k < 22; k++) begin
            step(1'b1, 1'b1);
            exp_buf[k+1] = 1'b1;
        end
        chk("run22", bus.run_length, 22);
        chk("run22_rct", bus.rct_failure, 0);
        chk("run22_idx", bus.index_of_last_bit, 22);
        step(1'b1, 1'b1);
        exp_buf[23] = 1'b1;
        chk("run23", bus.run_length, 23);
        chk("run23_rct", bus.rct_failure, 1);
        chk("run23_idx", bus.index_of_last_bit, 23);
        chk("run23_bv", bus.block_valid, 0);
        chk("rct_align", bus.random_bits[23:1], 23'h7fffff);
        chk("run23_bits", bus.random_bits, exp_buf);

        // FAULT: bits and ready ignored
        bus.block_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1);
            chk("drop_fault", bus.bit_dropped, 1);
        end
        bus.block_ready = 1'b0;
        chk("fault_bits", bus.random_bits, exp_buf);
        chk("fault_idx", bus.index_of_last_bit, 23);
        chk("fault_rct", bus.rct_failure, 1);
        chk("fault_bv", bus.block_valid, 0);

        pulse_clear();
        chk("clr_rct", bus.rct_failure, 0);
        chk("clr_run", bus.run_length, 0);
        chk("clr_drop", bus.bit_dropped, 0);

        step(1'b1, 1'b1);
        exp_buf[24] = 1'b1;
        chk("post_clr_run", bus.run_length, 1);
        chk("post_clr_idx", bus.index_of_last_bit, 24);
        chk("post_clr_bits", bus.random_bits, exp_buf);

        // Block N: indices 25..1023,0..23, last 12 bits (idx 12..23) are ones
        for (int n = 1; n < 1024; n++) begin
            p = (24 + n) % 1024;
            b = (p >= 12 && p <= 23) ? 1'b1 : ~p[0];
            step(1'b1, b);
            exp_buf[p] = b;
            if (p == 1023) chk("blk_idx1023", bus.index_of_last_bit, 1023);
            if (p == 0)    chk("blk_idx_wrap", bus.index_of_last_bit, 0);
            if (p == 0)    chk("blk_bv_mid", bus.block_valid, 0);
        end
        chk("blkN_bv", bus.block_valid, 1);
        chk("blkN_run", bus.run_length, 12);
        chk("blkN_idx", bus.index_of_last_bit, 23);
        chk("blkN_bits", bus.random_bits, exp_buf);

        bus.block_ready = 1'b1;
        @(negedge clk);
        bus.block_ready = 1'b0;
        chk("blkN_hs_bv", bus.block_valid, 0);
        chk("blkN_hs_run", bus.run_length, 12);

        // Block N+1: 11th one trips the fault (12 + 11 = 23)
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1);
            exp_buf[24+k] = 1'b1;
        end
        chk("span_run22", bus.run_length, 22);
        chk("span_rct0", bus.rct_failure, 0);
        step(1'b1, 1'b1);
        exp_buf[34] = 1'b1;
        chk("span_rct1", bus.rct_failure, 1);
        chk("span_run23", bus.run_length, 23);
        chk("span_idx", bus.index_of_last_bit, 34);
        chk("span_bits", bus.random_bits, exp_buf);

        // Mid-block reset after 500 accepted bits
        pulse_clear();
        for (int k = 0; k < 500; k++) step(1'b1, k[0]);
        chk("pre_rst_idx", bus.index_of_last_bit, 534);
        rst = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        rst = 1'b0;
        chk("rst2_bits", bus.random_bits, '0);
        chk("rst2_idx", bus.index_of_last_bit, 0);
        chk("rst2_run", bus.run_length, 0);
        chk("rst2_bv", bus.block_valid, 0);
        chk("rst2_rct", bus.rct_failure, 0);
        chk("rst2_drop", bus.bit_dropped, 0);

        for (int k = 0; k < 1023; k++) step(1'b1, k[0]);
        chk("refill_bv0", bus.block_valid, 0);
        step(1'b1, 1'b1);
        chk("refill_bv1", bus.block_valid, 1);
        chk("refill_idx", bus.index_of_last_bit, 1023);
        chk("refill_bits", bus.random_bits, {512{2'b10}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
